imem_loader: RTL and testbench

- Boot-time writer for the processor's byte-addressed instruction memory. It is the hardware counterpart of the bench's file-based imem preload.
- Receives a framed byte stream over a valid/ready handshake and writes each byte into the imem storage byte port.
- Holds the CPU in reset until a frame completes with a correct checksum.
- Sits between the host/debug link and the IFU imemory.

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/loader_byte_writer.sv | 38 +++
 rtl/imem_loader.sv | 73 +++++++
 tb/tb_imem_loader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encodings and frame layout constants.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    LOADER_ST_IDLE   = 3'd0,
    LOADER_ST_LEN_HI = 3'd1,
    LOADER_ST_LEN_LO = 3'd2,
    LOADER_ST_DATA   = 3'd3,
    LOADER_ST_CSUM   = 3'd4,
    LOADER_ST_DONE   = 3'd5,
    LOADER_ST_ERR    = 3'd6
  } loader_st_e;
  localparam int LOADER_HDR_LEN = 2;
endpackage

// File: rtl/loader_byte_writer.sv
// loader_byte_writer: registered imem write stage with address pointer and payload XOR accumulator.
module loader_byte_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [7:0]            wr_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [7:0]            acc
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  logic [ADDR_WIDTH-1:0] ptr;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= BASE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 8'd0;
      acc       <= 8'd0;
    end else begin
      mem_we <= wr;
      if (clear) begin
        ptr <= BASE;
        acc <= 8'd0;
      end else if (wr) begin
        ptr       <= ptr + 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= wr_byte;
        acc       <= acc ^ wr_byte;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into imem, holding the CPU until a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  localparam logic [63:0] CAP = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
  loader_st_e state, state_nx;
  logic [7:0] len_hi, acc;
  logic [17:0] cnt, frame_bytes;
  logic [15:0] n;
  logic take, start_ok, oversize;
  assign n           = {len_hi, in_data};
  assign frame_bytes = {n, 2'b00};
  assign oversize    = {46'd0, frame_bytes} > CAP;
  assign in_ready    = state inside {LOADER_ST_LEN_HI, LOADER_ST_LEN_LO, LOADER_ST_DATA, LOADER_ST_CSUM};
  assign take        = in_valid && in_ready;
  assign start_ok    = start && (state inside {LOADER_ST_IDLE, LOADER_ST_DONE, LOADER_ST_ERR});
  assign done        = state == LOADER_ST_DONE;
  assign error       = state == LOADER_ST_ERR;
  assign cpu_hold    = state != LOADER_ST_DONE;
  always_comb begin
    state_nx = state;
    case (state)
      LOADER_ST_IDLE, LOADER_ST_DONE, LOADER_ST_ERR:
        state_nx = start ? LOADER_ST_LEN_HI : state;
      LOADER_ST_LEN_HI: state_nx = in_valid ? LOADER_ST_LEN_LO : state;
      LOADER_ST_LEN_LO:
        state_nx = !in_valid ? state : n == 16'd0 ? LOADER_ST_CSUM : oversize ? LOADER_ST_ERR : LOADER_ST_DATA;
      LOADER_ST_DATA: state_nx = in_valid && cnt == 18'd1 ? LOADER_ST_CSUM : state;
      LOADER_ST_CSUM:
        state_nx = !in_valid ? state : in_data == acc ? LOADER_ST_DONE : LOADER_ST_ERR;
      default: state_nx = LOADER_ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= LOADER_ST_IDLE;
      len_hi <= 8'd0;
      cnt    <= 18'd0;
    end else begin
      state <= state_nx;
      if (take && state == LOADER_ST_LEN_HI) len_hi <= in_data;
      if (take && state == LOADER_ST_LEN_LO) cnt <= frame_bytes;
      else if (take && state == LOADER_ST_DATA) cnt <= cnt - 18'd1;
    end
  end
  loader_byte_writer #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_writer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start_ok),
    .wr        (take && state == LOADER_ST_DATA),
    .wr_byte   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .acc       (acc)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level model plus directed frames for the imem loader.
module tb_imem_loader;
  logic clk, reset_n, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, mem_we, cpu_hold, done, error;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic in_ready4, mem_we4, cpu_hold4, done4, error4;
  logic [3:0] mem_addr4;
  logic [7:0] mem_wdata4;
  int errors = 0, checks = 0, we_cnt = 0, we4_cnt = 0;
  bit en = 0;
  logic [7:0] dmem [1024];
  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error));
  imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .cpu_hold(cpu_hold4), .done(done4), .error(error4));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask
  // Frame-level model: position within the frame decides what each accepted byte means.
  bit m_busy = 0, m_we = 0;
  int m_res = 0, m_pos = 0, m_hi = 0, m_nbytes = 0, m_acc = 0, m_ptr = 0, m_addr = 0, m_data = 0;
  initial forever begin
    @(posedge clk);
    m_we = 0;
    if (!reset_n) begin
      m_busy = 0; m_res = 0;
    end else if (start && !m_busy) begin
      m_busy = 1; m_pos = 0; m_acc = 0; m_ptr = 0; m_res = 0;
    end else if (m_busy && in_valid) begin
      if (m_pos == 0) m_hi = in_data;
      else if (m_pos == 1) begin
        m_nbytes = (m_hi * 256 + in_data) * 4;
        if (m_nbytes > 1024) begin m_busy = 0; m_res = 2; end
      end else if (m_pos < 2 + m_nbytes) begin
        m_we = 1; m_addr = m_ptr; m_data = in_data; m_ptr++; m_acc = m_acc ^ in_data;
      end else begin
        m_busy = 0; m_res = (in_data == m_acc) ? 1 : 2;
      end
      m_pos++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (mem_we) begin dmem[mem_addr] = mem_wdata; we_cnt++; end
    if (mem_we4) we4_cnt++;
    if (en) begin
      chk("in_ready", in_ready, m_busy);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
      chk("done", done, m_res == 1);
      chk("error", error, m_res == 2);
      chk("cpu_hold", cpu_hold, m_res != 1);
    end
  end
  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_start();
    start = 1; cyc(1); start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    in_valid = 1; in_data = b;
    while (!in_ready && t < 20) begin cyc(1); t++; end
    if (t == 20) chk("handshake_timeout", 1, 0);
    cyc(1);
    in_valid = 0;
    if (gap) cyc(1);
  endtask
  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    foreach (f[i]) send(f[i], gap);
  endtask
  task automatic clear_mem();
    foreach (dmem[i]) dmem[i] = 8'h00;
    we_cnt = 0; we4_cnt = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask
  task automatic chk_image(input string tag, input logic [7:0] img[$]);
    foreach (img[i]) chk($sformatf("%s_mem%0d", tag, i), dmem[i], img[i]);
  endtask
  logic [7:0] frame_a[$] = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h01, 8'h20, 8'h11, 8'h00, 8'h02, 8'h02};
  logic [7:0] frame_bad[$] = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h01, 8'h20, 8'h11, 8'h00, 8'h02, 8'h03};
  logic [7:0] frame_b[$] = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
  logic [7:0] img_a[$] = '{8'h20, 8'h10, 8'h00, 8'h01, 8'h20, 8'h11, 8'h00, 8'h02};
  logic [7:0] img_b[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  initial begin
    reset_n = 0; start = 0; in_valid = 0; in_data = 0;
    cyc(2);
    chk_reset_outputs("reset");
    en = 1; reset_n = 1;
    cyc(2);
    clear_mem();
    pulse_start();
    send_frame(frame_a, 0);
    chk("a_done", done, 1); chk("a_cpu_hold", cpu_hold, 0); chk("a_writes", we_cnt, 8);
    chk_image("a", img_a);
    cyc(2);
    clear_mem();
    pulse_start();
    send_frame(frame_a, 1);
    chk("gap_done", done, 1); chk("gap_writes", we_cnt, 8);
    chk_image("gap", img_a);
    pulse_start();
    send_frame(frame_bad, 0);
    chk("bad_error", error, 1); chk("bad_cpu_hold", cpu_hold, 1); chk("bad_done", done, 0);
    cyc(2);
    pulse_start();
    send_frame(frame_a, 0);
    chk("recover_done", done, 1); chk("recover_error", error, 0);
    clear_mem();
    pulse_start();
    send(8'h00, 0); send(8'h05, 0);
    chk("over_error4", error4, 1); chk("over_hold4", cpu_hold4, 1); chk("over_ready4", in_ready4, 0);
    cyc(3);
    chk("over_writes4", we4_cnt, 0);
    reset_n = 0; cyc(1); reset_n = 1;
    clear_mem();
    pulse_start();
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    chk("n0_done", done, 1); chk("n0_writes", we_cnt, 0);
    pulse_start();
    send_frame('{8'h00, 8'h00, 8'h01}, 0);
    chk("n0_bad_error", error, 1); chk("n0_bad_done", done, 0);
    clear_mem();
    pulse_start();
    send_frame('{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC}, 0);
    reset_n = 0; cyc(1); reset_n = 1;
    chk_reset_outputs("midreset");
    chk_image("partial", '{8'hAA, 8'hBB, 8'hCC});
    pulse_start();
    send_frame(frame_b, 0);
    chk("b_done", done, 1); chk("b_cpu_hold", cpu_hold, 0);
    chk_image("b", img_b);
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
